// File: rtl/gray_pkg.sv
// gray_pkg: shared types, widths and arithmetic helpers for the gray stream controller
// Build option: GRAY_STREAM_LUMA_EN selects weighted luma instead of the plain RGB average.
package gray_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_SOF, RUN, DRAIN} state_t;
  typedef struct packed {
    logic sof;
    logic eol;
    logic last;
  } tag_t;
  localparam int PIX_W  = 8;
  localparam int LUMA_R = 77;
  localparam int LUMA_G = 150;
  localparam int LUMA_B = 29;
`ifdef GRAY_STREAM_LUMA_EN
  localparam int SUM_W = 16;
`else
  localparam int SUM_W = 10;
`endif
  function automatic int cnt_w(input int n);
    return n > 2 ? $clog2(n) : 1;
  endfunction
  function automatic logic [SUM_W-1:0] pix_sum(input logic [23:0] rgb);
`ifdef GRAY_STREAM_LUMA_EN
    return 16'(LUMA_R) * 16'(rgb[23:16]) + 16'(LUMA_G) * 16'(rgb[15:8]) + 16'(LUMA_B) * 16'(rgb[7:0]);
`else
    return 10'(rgb[23:16]) + 10'(rgb[15:8]) + 10'(rgb[7:0]);
`endif
  endfunction
  // 683/2048 overshoots 1/3 by s/6144, which stays below the 1/3 margin for every s < 2048
  function automatic logic [PIX_W-1:0] gray_of(input logic [SUM_W-1:0] s);
`ifdef GRAY_STREAM_LUMA_EN
    return PIX_W'(s >> 8);
`else
    return PIX_W'((20'(s) * 20'd683) >> 11);
`endif
  endfunction
endpackage

// File: rtl/gray_stream_ctrl_if.sv
// gray_stream_ctrl_if: control, RGB input stream and gray output stream of the controller
// slave modport is the controller view; master modport is the environment driving it.
interface gray_stream_ctrl_if;
  import gray_pkg::*;
  logic             start;
  logic [23:0]      s_rgb;
  logic             s_sof;
  logic             s_valid;
  logic             s_ready;
  logic [PIX_W-1:0] m_gray;
  logic             m_sof;
  logic             m_eol;
  logic             m_valid;
  logic             m_ready;
  logic             busy;
  logic             frame_done;
  logic             err_sof;
  modport slave (
    input  start, s_rgb, s_sof, s_valid, m_ready,
    output s_ready, m_gray, m_sof, m_eol, m_valid, busy, frame_done, err_sof
  );
  modport master (
    output start, s_rgb, s_sof, s_valid, m_ready,
    input  s_ready, m_gray, m_sof, m_eol, m_valid, busy, frame_done, err_sof
  );
endinterface

// File: rtl/gray_pipe.sv
// gray_pipe: two-stage RGB-to-gray pipeline with valid/ready and a sideband tag
// Ports: clk, rst_n (async active-low); in_rgb/in_tag/in_valid/in_ready upstream;
// out_gray/out_tag/out_valid/out_ready downstream. Stage 1 sums, stage 2 scales.
module gray_pipe
  import gray_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [23:0]      in_rgb,
  input  tag_t             in_tag,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [PIX_W-1:0] out_gray,
  output tag_t             out_tag,
  output logic             out_valid,
  input  logic             out_ready
);
  logic [SUM_W-1:0] sum1;
  tag_t tag1;
  logic v1, en1, en2;
  assign en2 = !out_valid || out_ready;
  assign en1 = !v1 || en2;
  assign in_ready = en1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1 <= 1'b0;
      sum1 <= '0;
      tag1 <= '0;
      out_valid <= 1'b0;
      out_gray <= '0;
      out_tag <= '0;
    end else begin
      if (en1) begin
        v1 <= in_valid;
        sum1 <= pix_sum(in_rgb);
        tag1 <= in_tag;
      end
      if (en2) begin
        out_valid <= v1;
        out_gray <= gray_of(sum1);
        out_tag <= tag1;
      end
    end
endmodule

// File: rtl/gray_stream_ctrl.sv
// gray_stream_ctrl: frame sequencer feeding an RGB stream through gray_pipe
// Ports: clk, rst_n (async active-low), bus (gray_stream_ctrl_if.slave): start, s_* input
// stream, m_* gray output stream with sof/eol tags, busy, frame_done, err_sof.
// err_sof pulses the cycle after the offending beat is accepted; frame_done pulses with
// the handshake of the last pixel. Build option: GRAY_STREAM_LUMA_EN (weighted luma).
module gray_stream_ctrl
  import gray_pkg::*;
#(
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter bit CONTINUOUS = 1'b0
) (
  input logic clk,
  input logic rst_n,
  gray_stream_ctrl_if.slave bus
);
  localparam int XW = cnt_w(IMG_W);
  localparam int YW = cnt_w(IMG_H);
  state_t state, state_nx;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic rdy, acc, load, pos0, restart, at_eol, at_last, pipe_rdy, done, err_q;
  tag_t tag, out_tag;
  assign pos0 = x == '0 && y == '0;
  assign at_eol = x == XW'(IMG_W - 1);
  assign at_last = at_eol && y == YW'(IMG_H - 1);
  // a sof anywhere past (0,0) aborts the frame and this beat becomes the new (0,0)
  assign restart = state == RUN && bus.s_sof && !pos0;
  assign tag = '{sof: pos0 || restart, eol: at_eol && !restart, last: at_last && !restart};
  assign acc = bus.s_valid && rdy;
  assign load = acc && (state == RUN || bus.s_sof);
  assign done = state == DRAIN && bus.m_valid && bus.m_ready && out_tag.last;
  always_comb begin
    state_nx = state;
    rdy = 1'b0;
    case (state)
      IDLE: state_nx = bus.start ? WAIT_SOF : IDLE;
      WAIT_SOF: begin
        rdy = 1'b1;
        state_nx = bus.s_valid && bus.s_sof ? RUN : WAIT_SOF;
      end
      RUN: begin
        rdy = pipe_rdy;
        state_nx = bus.s_valid && pipe_rdy && tag.last ? DRAIN : RUN;
      end
      default: state_nx = done ? (CONTINUOUS ? WAIT_SOF : IDLE) : DRAIN;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      x <= '0;
      y <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= acc && restart;
      if (load) begin
        x <= restart ? XW'(1) : at_eol ? '0 : x + 1'b1;
        y <= restart || at_last ? '0 : at_eol ? y + 1'b1 : y;
      end
    end
  gray_pipe u_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_rgb   (bus.s_rgb),
    .in_tag   (tag),
    .in_valid (load),
    .in_ready (pipe_rdy),
    .out_gray (bus.m_gray),
    .out_tag  (out_tag),
    .out_valid(bus.m_valid),
    .out_ready(bus.m_ready)
  );
  assign bus.s_ready = rdy;
  assign bus.m_sof = out_tag.sof;
  assign bus.m_eol = out_tag.eol;
  assign bus.busy = state != IDLE;
  assign bus.frame_done = done;
  assign bus.err_sof = err_q;
endmodule
